fetch_stage: RTL and testbench

Instruction fetch stage of the 16-bit pipelined core. It sits directly upstream of the hazard controller.
- Owns the PC and drives the synchronous instruction block RAM.
- Produces the IF/ID pipeline register, whose instruction and opcode the hazard controller inspects.
- Obeys the controller's stall and the execute stage's branch/jump redirect, and flushes wrong-path instructions as bubbles.

---
 rtl/fetch_stage.sv | 90 +++++++++
 tb/tb_fetch_stage.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the synchronous instruction BRAM
// and produces the IF/ID register consumed by the hazard controller.
module fetch_stage #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] NOP_WORD   = 16'h0000,
  parameter logic [2:0]  BR_OPCODE  = 3'b100,
  parameter logic [2:0]  JMP_OPCODE = 3'b101
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] imem_addr,
  output logic        imem_en,
  input  logic [15:0] imem_data,
  output logic [15:0] ifid_instruc,
  output logic [2:0]  ifid_opcode,
  output logic [15:0] ifid_pc_plus1,
  output logic        ifid_valid,
  output logic        ifid_ctrl,
  output logic [15:0] fetch_count
);

  logic [15:0] pc_q, pc_d;
  logic [15:0] fetch_pc_q, fetch_pc_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic [15:0] ifid_instruc_q, ifid_instruc_d;
  logic [15:0] ifid_pc_plus1_q, ifid_pc_plus1_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [15:0] fetch_count_q, fetch_count_d;

  always_comb begin
    pc_d            = pc_q;
    fetch_pc_d      = fetch_pc_q;
    fetch_valid_d   = fetch_valid_q;
    ifid_instruc_d  = ifid_instruc_q;
    ifid_pc_plus1_d = ifid_pc_plus1_q;
    ifid_valid_d    = ifid_valid_q;
    fetch_count_d   = fetch_count_q;
    if (redirect) begin
      // The word arriving next cycle and the one in IF/ID are both wrong-path.
      pc_d           = redirect_pc;
      fetch_valid_d  = 1'b0;
      ifid_instruc_d = NOP_WORD;
      ifid_valid_d   = 1'b0;
    end else if (!stall) begin
      pc_d            = pc_q + 16'd1;
      fetch_pc_d      = pc_q;
      fetch_valid_d   = 1'b1;
      ifid_instruc_d  = fetch_valid_q ? imem_data : NOP_WORD;
      ifid_valid_d    = fetch_valid_q;
      ifid_pc_plus1_d = fetch_pc_q + 16'd1;
      fetch_count_d   = fetch_count_q + {15'd0, fetch_valid_q};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q            <= RESET_PC;
      fetch_pc_q      <= 16'h0000;
      fetch_valid_q   <= 1'b0;
      ifid_instruc_q  <= NOP_WORD;
      ifid_pc_plus1_q <= 16'h0000;
      ifid_valid_q    <= 1'b0;
      fetch_count_q   <= 16'h0000;
    end else begin
      pc_q            <= pc_d;
      fetch_pc_q      <= fetch_pc_d;
      fetch_valid_q   <= fetch_valid_d;
      ifid_instruc_q  <= ifid_instruc_d;
      ifid_pc_plus1_q <= ifid_pc_plus1_d;
      ifid_valid_q    <= ifid_valid_d;
      fetch_count_q   <= fetch_count_d;
    end
  end

  // With the enable low the BRAM keeps presenting the stalled word.
  assign imem_addr     = pc_q;
  assign imem_en       = reset | redirect | ~stall;
  assign ifid_instruc  = ifid_instruc_q;
  assign ifid_opcode   = ifid_instruc_q[15:13];
  assign ifid_pc_plus1 = ifid_pc_plus1_q;
  assign ifid_valid    = ifid_valid_q;
  assign ifid_ctrl     = ifid_valid_q &&
                         (ifid_instruc_q[15:13] == BR_OPCODE ||
                          ifid_instruc_q[15:13] == JMP_OPCODE);
  assign fetch_count   = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the stimulus queues the expected IF/ID
// content for every advancing edge; a monitor pops and compares after each one.
module tb_fetch_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [15:0] imem_addr;
  logic        imem_en;
  logic [15:0] imem_data = 16'h0000;
  logic [15:0] ifid_instruc;
  logic [2:0]  ifid_opcode;
  logic [15:0] ifid_pc_plus1;
  logic        ifid_valid;
  logic        ifid_ctrl;
  logic [15:0] fetch_count;

  fetch_stage dut (
    .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_en(imem_en),
    .imem_data(imem_data), .ifid_instruc(ifid_instruc), .ifid_opcode(ifid_opcode),
    .ifid_pc_plus1(ifid_pc_plus1), .ifid_valid(ifid_valid), .ifid_ctrl(ifid_ctrl),
    .fetch_count(fetch_count)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] word_at(input logic [15:0] a);
    if (a == 16'hFFFF) return 16'h8000;
    if (a == 16'h0081) return 16'hA123;
    return 16'h1000 + a;
  endfunction

  always @(posedge clock) if (imem_en) imem_data <= word_at(imem_addr);

  typedef struct {
    logic        v;
    logic [15:0] ins;
    logic [15:0] pcp1;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Monitor: an edge with reset, stall and redirect all low advances IF/ID.
  logic mon_adv;
  always @(posedge clock) begin
    mon_adv = !reset && !stall && !redirect;
    @(negedge clock);
    if (mon_adv) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb_unexpected: got ifid %h valid %b expected no advance", ifid_instruc, ifid_valid);
      end else begin
        exp_t e;
        logic [2:0] op;
        e = exp_q.pop_front();
        op = e.ins[15:13];
        chk("sb_valid", {15'd0, ifid_valid}, {15'd0, e.v});
        chk("sb_instruc", ifid_instruc, e.ins);
        if (e.v) begin
          chk("sb_pc_plus1", ifid_pc_plus1, e.pcp1);
          chk("sb_opcode", {13'd0, ifid_opcode}, {13'd0, op});
        end
        chk("sb_ctrl", {15'd0, ifid_ctrl},
            {15'd0, e.v && (op == 3'b100 || op == 3'b101)});
      end
    end
  end

  task automatic cyc(input logic r, input logic s, input logic rd, input logic [15:0] rpc);
    reset = r; stall = s; redirect = rd; redirect_pc = rpc;
    @(posedge clock);
    #1;
  endtask

  task automatic adv_bubble();
    exp_t e;
    e.v = 1'b0; e.ins = 16'h0000; e.pcp1 = 16'h0000;
    exp_q.push_back(e);
    cyc(0, 0, 0, 16'h0000);
  endtask

  task automatic adv_word(input logic [15:0] ins, input logic [15:0] pcp1);
    exp_t e;
    e.v = 1'b1; e.ins = ins; e.pcp1 = pcp1;
    exp_q.push_back(e);
    cyc(0, 0, 0, 16'h0000);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, {15'd0, ifid_valid}, 16'd0);
    chk({tag, "_instruc"}, ifid_instruc, 16'h0000);
    chk({tag, "_pc_plus1"}, ifid_pc_plus1, 16'h0000);
    chk({tag, "_count"}, fetch_count, 16'd0);
    chk({tag, "_ctrl"}, {15'd0, ifid_ctrl}, 16'd0);
    chk({tag, "_addr"}, imem_addr, 16'h0000);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(1, 0, 0, 16'h0000);
    cyc(1, 0, 0, 16'h0000);
    chk_reset_state("reset");

    adv_bubble();
    adv_word(16'h1000, 16'h0001);
    adv_word(16'h1001, 16'h0002);
    adv_word(16'h1002, 16'h0003);
    adv_word(16'h1003, 16'h0004);
    chk("count_run", fetch_count, 16'd4);
    chk("en_run", {15'd0, imem_en}, 16'd1);

    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 16'h0000);
      chk("stall_ifid", ifid_instruc, 16'h1003);
      chk("stall_addr", imem_addr, 16'h0005);
      chk("stall_en", {15'd0, imem_en}, 16'd0);
      chk("stall_count", fetch_count, 16'd4);
    end
    adv_word(16'h1004, 16'h0005);
    adv_word(16'h1005, 16'h0006);
    chk("count_after_stall", fetch_count, 16'd6);

    cyc(0, 0, 1, 16'h0040);
    chk("redir_valid", {15'd0, ifid_valid}, 16'd0);
    chk("redir_instruc", ifid_instruc, 16'h0000);
    chk("redir_addr", imem_addr, 16'h0040);
    chk("redir_count", fetch_count, 16'd6);
    adv_bubble();
    adv_word(16'h1040, 16'h0041);
    adv_word(16'h1041, 16'h0042);

    cyc(0, 1, 1, 16'h0080);
    chk("redir_stall_addr", imem_addr, 16'h0080);
    chk("redir_stall_valid", {15'd0, ifid_valid}, 16'd0);
    chk("redir_stall_en", {15'd0, imem_en}, 16'd1);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 1, 0, 16'h0000);
      chk("post_redir_stall_valid", {15'd0, ifid_valid}, 16'd0);
      chk("post_redir_stall_addr", imem_addr, 16'h0080);
      chk("post_redir_stall_en", {15'd0, imem_en}, 16'd0);
    end
    adv_bubble();
    adv_word(16'h1080, 16'h0081);
    adv_word(16'hA123, 16'h0082);
    chk("count_jmp", fetch_count, 16'd10);

    cyc(0, 0, 1, 16'hFFFF);
    adv_bubble();
    chk("wrap_addr", imem_addr, 16'h0000);
    adv_word(16'h8000, 16'h0000);
    adv_word(16'h1000, 16'h0001);
    chk("count_wrap", fetch_count, 16'd12);

    cyc(0, 1, 0, 16'h0000);
    cyc(1, 1, 0, 16'h0000);
    chk_reset_state("reset_in_stall");
    cyc(1, 0, 1, 16'h1234);
    chk("reset_in_redir_addr", imem_addr, 16'h0000);

    adv_bubble();
    adv_word(16'h1000, 16'h0001);
    chk("count_after_reset", fetch_count, 16'd1);

    cyc(0, 1, 0, 16'h0000);
    cyc(0, 1, 0, 16'h0000);
    chk("sb_drained", exp_q.size(), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
